// File: rtl/md_ctrl.sv
// HI/LO and multiply/divide sequencing for the ID stage: decodes HI/LO-class
// instructions, launches the external mult/div datapath, and holds HI/LO.
module md_ctrl (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] id_instr,
  input  logic        id_valid,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  output logic        md_start,
  output logic [1:0]  md_op,
  output logic [31:0] md_a,
  output logic [31:0] md_b,
  input  logic        md_done,
  input  logic [31:0] md_hi_res,
  input  logic [31:0] md_lo_res,
  output logic [31:0] hi_out,
  output logic [31:0] lo_out,
  output logic        stall,
  output logic        div0,
  output logic        md_timeout
);

  // state | meaning
  // IDLE  | no op in flight; HI/LO-class instructions execute or launch here
  // ISSUE | md_start high for this one cycle, operands latched
  // BUSY  | waiting for md_done, watchdog counting
  typedef enum logic [1:0] {IDLE, ISSUE, BUSY} stateT;

  stateT      state;
  logic [5:0] wdCnt;
  logic [5:0] funct;
  logic       special, isMul, isDiv, isMthi, isMtlo, isMf, isHiLo;
  logic       unusedBits;

  assign funct      = id_instr[5:0];
  assign special    = (id_instr[31:26] == 6'd0);
  assign unusedBits = ^id_instr[25:6];

  assign isMul  = special & ((funct == 6'b011000) | (funct == 6'b011001));
  assign isDiv  = special & ((funct == 6'b011010) | (funct == 6'b011011));
  assign isMthi = special & (funct == 6'b010001);
  assign isMtlo = special & (funct == 6'b010011);
  assign isMf   = special & ((funct == 6'b010000) | (funct == 6'b010010));
  assign isHiLo = isMul | isDiv | isMthi | isMtlo | isMf;

  assign stall = id_valid & isHiLo & (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      wdCnt      <= 6'd0;
      hi_out     <= 32'd0;
      lo_out     <= 32'd0;
      md_a       <= 32'd0;
      md_b       <= 32'd0;
      md_op      <= 2'b00;
      md_start   <= 1'b0;
      div0       <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      md_start <= 1'b0;
      div0     <= 1'b0;
      case (state)
        IDLE: begin
          if (id_valid) begin
            if (isMul || (isDiv && (rt_val != 32'd0))) begin
              md_a     <= rs_val;
              md_b     <= rt_val;
              md_op    <= funct[1:0];
              md_start <= 1'b1;
              wdCnt    <= 6'd0;
              state    <= ISSUE;
            end else if (isDiv) begin
              div0 <= 1'b1;
            end else if (isMthi) begin
              hi_out <= rs_val;
            end else if (isMtlo) begin
              lo_out <= rs_val;
            end
          end
        end
        ISSUE: begin
          if (md_done) begin
            hi_out <= md_hi_res;
            lo_out <= md_lo_res;
            state  <= IDLE;
          end else begin
            state <= BUSY;
          end
        end
        BUSY: begin
          if (md_done) begin
            hi_out <= md_hi_res;
            lo_out <= md_lo_res;
            state  <= IDLE;
          end else begin
            wdCnt <= wdCnt + 6'd1;
            // counter becomes 48 at this edge: the 48th BUSY cycle just ended
            if (wdCnt == 6'd47) begin
              md_timeout <= 1'b1;
              state      <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_ctrl.sv
// Randomized + directed bench for md_ctrl, checked every cycle against a
// cycle-counting behavioural model of the HI/LO unit.
module tb_md_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [31:0] id_instr = 32'd0;
  logic        id_valid = 1'b0;
  logic [31:0] rs_val = 32'd0, rt_val = 32'd0;
  logic        md_start;
  logic [1:0]  md_op;
  logic [31:0] md_a, md_b;
  logic        md_done = 1'b0;
  logic [31:0] md_hi_res = 32'd0, md_lo_res = 32'd0;
  logic [31:0] hi_out, lo_out;
  logic        stall, div0, md_timeout;

  int nChecks = 0;
  int nErrors = 0;

  md_ctrl dut (
    .clk(clk), .rst_n(rst_n), .id_instr(id_instr), .id_valid(id_valid),
    .rs_val(rs_val), .rt_val(rt_val), .md_start(md_start), .md_op(md_op),
    .md_a(md_a), .md_b(md_b), .md_done(md_done), .md_hi_res(md_hi_res),
    .md_lo_res(md_lo_res), .hi_out(hi_out), .lo_out(lo_out), .stall(stall),
    .div0(div0), .md_timeout(md_timeout)
  );

  always #5 clk = ~clk;

  // model: an op is "pending" from acceptance until done/timeout; age counts
  // cycles since acceptance (age 1 = launch cycle, age-1 = BUSY cycles so far)
  bit          mPending, mDiv0, mTimeout;
  int          mAge;
  logic [31:0] mHi, mLo, mA, mB;
  logic [1:0]  mOp;

  localparam int K_NONE = 0, K_MUL = 1, K_DIV = 2, K_MTHI = 3, K_MTLO = 4, K_MF = 5;

  function automatic int kindOf(input logic [31:0] ins);
    if (ins[31:26] != 6'd0) return K_NONE;
    case (ins[5:0])
      6'b011000, 6'b011001: return K_MUL;
      6'b011010, 6'b011011: return K_DIV;
      6'b010001:            return K_MTHI;
      6'b010011:            return K_MTLO;
      6'b010000, 6'b010010: return K_MF;
      default:              return K_NONE;
    endcase
  endfunction

  function automatic logic [31:0] mkR(input logic [5:0] fn);
    logic [19:0] mid;
    mid = 20'($urandom);
    return {6'd0, mid, fn};
  endfunction

  task automatic modelReset();
    mPending = 0; mDiv0 = 0; mTimeout = 0; mAge = 0;
    mHi = 0; mLo = 0; mA = 0; mB = 0; mOp = 0;
  endtask

  task automatic checkEq(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nErrors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll();
    int k;
    k = kindOf(id_instr);
    checkEq("stall", 32'(stall), 32'(id_valid && (k != K_NONE) && mPending));
    checkEq("md_start", 32'(md_start), 32'(mPending && mAge == 1));
    checkEq("div0", 32'(div0), 32'(mDiv0));
    checkEq("md_timeout", 32'(md_timeout), 32'(mTimeout));
    checkEq("hi_out", hi_out, mHi);
    checkEq("lo_out", lo_out, mLo);
    checkEq("md_a", md_a, mA);
    checkEq("md_b", md_b, mB);
    checkEq("md_op", 32'(md_op), 32'(mOp));
  endtask

  task automatic advance();
    int k;
    bit nextDiv0;
    k = kindOf(id_instr);
    nextDiv0 = 0;
    if (!mPending) begin
      if (id_valid) begin
        if (k == K_MUL || (k == K_DIV && rt_val != 0)) begin
          mPending = 1; mAge = 1; mA = rs_val; mB = rt_val; mOp = id_instr[1:0];
        end else if (k == K_DIV) nextDiv0 = 1;
        else if (k == K_MTHI) mHi = rs_val;
        else if (k == K_MTLO) mLo = rs_val;
      end
    end else if (md_done) begin
      mHi = md_hi_res; mLo = md_lo_res; mPending = 0;
    end else if (mAge - 1 == 48) begin
      mTimeout = 1; mPending = 0;
    end else begin
      mAge++;
    end
    mDiv0 = nextDiv0;
  endtask

  task automatic step(input logic [31:0] ins, input logic v, input logic [31:0] a,
                      input logic [31:0] b, input logic d, input logic [31:0] hr,
                      input logic [31:0] lr);
    @(negedge clk);
    id_instr = ins; id_valid = v; rs_val = a; rt_val = b;
    md_done = d; md_hi_res = hr; md_lo_res = lr;
    #1;
    checkAll();
    advance();
  endtask

  task automatic applyReset();
    rst_n = 1'b0;
    id_valid = 1'b0; md_done = 1'b0;
    #1;
    checkEq("rst_hi", hi_out, 32'd0);
    checkEq("rst_lo", lo_out, 32'd0);
    checkEq("rst_a", md_a, 32'd0);
    checkEq("rst_start", 32'(md_start), 32'd0);
    checkEq("rst_timeout", 32'(md_timeout), 32'd0);
    checkEq("rst_stall", 32'(stall), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic randomCycles(input int n);
    logic [31:0] ins, a, b;
    int sel;
    for (int i = 0; i < n; i++) begin
      sel = int'($urandom_range(0, 11));
      case (sel)
        0: ins = mkR(6'b011000);
        1: ins = mkR(6'b011001);
        2: ins = mkR(6'b011010);
        3: ins = mkR(6'b011011);
        4: ins = mkR(6'b010000);
        5: ins = mkR(6'b010001);
        6: ins = mkR(6'b010010);
        7: ins = mkR(6'b010011);
        8: ins = mkR(6'b100000);
        9: ins = {6'b001000, 20'($urandom), 6'b011000};
        default: ins = $urandom;
      endcase
      a = $urandom;
      b = ($urandom_range(0, 3) == 0) ? 32'd0 : $urandom;
      step(ins, $urandom_range(0, 4) != 0, a, b,
           mPending ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 3) == 0),
           $urandom, $urandom);
    end
  endtask

  localparam logic [31:0] ADD = 32'h0043_2020;

  initial begin
    modelReset();
    applyReset();
    randomCycles(600);

    // mult 3 * -2, done in cycle 3, dependent mflo
    step(mkR(6'b011000), 1, 32'h0000_0003, 32'hFFFF_FFFE, 0, 0, 0);
    step(mkR(6'b010010), 1, 0, 0, 0, 0, 0);
    checkEq("mult_start_c1", 32'(md_start), 32'd1);
    checkEq("mult_op_c1", 32'(md_op), 32'd0);
    checkEq("mult_a", md_a, 32'h3);
    checkEq("mult_b", md_b, 32'hFFFF_FFFE);
    checkEq("mflo_stall_c1", 32'(stall), 32'd1);
    step(mkR(6'b010010), 1, 0, 0, 0, 0, 0);
    checkEq("mflo_stall_c2", 32'(stall), 32'd1);
    step(mkR(6'b010010), 1, 0, 0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    checkEq("mflo_stall_c3", 32'(stall), 32'd1);
    step(mkR(6'b010010), 1, 0, 0, 0, 0, 0);
    checkEq("mflo_stall_c4", 32'(stall), 32'd0);
    checkEq("mult_hi", hi_out, 32'hFFFF_FFFF);
    checkEq("mult_lo", lo_out, 32'hFFFF_FFFA);

    // divu by zero
    step(mkR(6'b011011), 1, 32'd77, 32'd0, 0, 0, 0);
    checkEq("divz_stall", 32'(stall), 32'd0);
    step(ADD, 1, 0, 0, 0, 0, 0);
    checkEq("divz_div0", 32'(div0), 32'd1);
    checkEq("divz_nostart", 32'(md_start), 32'd0);
    checkEq("divz_hi", hi_out, 32'hFFFF_FFFF);
    step(ADD, 1, 0, 0, 0, 0, 0);
    checkEq("divz_div0_off", 32'(div0), 32'd0);

    // mthi then mfhi
    step(mkR(6'b010001), 1, 32'h1234_5678, 0, 0, 0, 0);
    step(mkR(6'b010000), 1, 0, 0, 0, 0, 0);
    checkEq("mthi_hi", hi_out, 32'h1234_5678);
    checkEq("mfhi_stall", 32'(stall), 32'd0);

    // add / mtlo while an op is outstanding
    step(mkR(6'b011001), 1, 32'd5, 32'd6, 0, 0, 0);
    step(ADD, 1, 0, 0, 0, 0, 0);
    checkEq("add_busy_stall", 32'(stall), 32'd0);
    step(mkR(6'b010011), 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    checkEq("mtlo_busy_stall", 32'(stall), 32'd1);
    step(mkR(6'b010011), 1, 32'hCAFE_F00D, 0, 1, 32'h1111, 32'h2222);
    checkEq("mtlo_done_stall", 32'(stall), 32'd1);
    step(mkR(6'b010011), 1, 32'hCAFE_F00D, 0, 0, 0, 0);
    checkEq("mtlo_release", 32'(stall), 32'd0);
    checkEq("mtlo_lo_res", lo_out, 32'h2222);
    step(ADD, 1, 0, 0, 0, 0, 0);
    checkEq("mtlo_lo", lo_out, 32'hCAFE_F00D);

    // div with no md_done: watchdog
    step(mkR(6'b011010), 1, 32'd100, 32'd7, 0, 0, 0);
    for (int c = 1; c <= 49; c++) step(mkR(6'b010000), 1, 0, 0, 0, 0, 0);
    checkEq("wd_stall_c49", 32'(stall), 32'd1);
    checkEq("wd_to_c49", 32'(md_timeout), 32'd0);
    step(mkR(6'b010000), 1, 0, 0, 0, 0, 0);
    checkEq("wd_to_c50", 32'(md_timeout), 32'd1);
    checkEq("wd_stall_c50", 32'(stall), 32'd0);
    checkEq("wd_hi_kept", hi_out, 32'h1111);
    randomCycles(40);

    // reset in BUSY, then a stale md_done
    step(mkR(6'b011000), 1, 32'd9, 32'd9, 0, 0, 0);
    step(ADD, 1, 0, 0, 0, 0, 0);
    step(ADD, 1, 0, 0, 0, 0, 0);
    applyReset();
    step(ADD, 0, 0, 0, 1, 32'hDEAD_BEEF, 32'hBEEF_DEAD);
    step(ADD, 0, 0, 0, 0, 0, 0);
    checkEq("post_rst_hi", hi_out, 32'd0);
    checkEq("post_rst_lo", lo_out, 32'd0);
    checkEq("post_rst_start", 32'(md_start), 32'd0);
    checkEq("post_rst_timeout", 32'(md_timeout), 32'd0);

    randomCycles(400);
    $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
    $finish;
  end

endmodule

// File: doc/md_ctrl.md
MD_CTRL -- requirements
Module: md_ctrl

Interface
REQ-001 SHALL provide: clk  in  1  sole clock; all state updates on rising edge.
REQ-002 SHALL provide: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL provide: id_instr  in  32  instruction currently in ID.
REQ-004 SHALL provide: id_valid  in  1  id_instr is a real (non-bubble) instruction.
REQ-005 SHALL provide: rs_val, rt_val  in  32 each  forwarded ID operands.
REQ-006 SHALL provide: md_start  out  1  one-cycle launch pulse to the external multiply/divide datapath.
REQ-007 SHALL provide: md_op  out  2  00 mult, 01 multu, 10 div, 11 divu; held stable while md_start is high.
REQ-008 SHALL provide: md_a, md_b  out  32 each  latched operands; held stable from ISSUE until the op completes.
REQ-009 SHALL provide: md_done  in  1  result-valid pulse; md_hi_res, md_lo_res  in  32 each  results.
REQ-010 SHALL provide: hi_out, lo_out  out  32 each  architectural HI/LO.
REQ-011 SHALL provide: stall  out  1  combinational hold request to IF/ID.
REQ-012 SHALL provide: div0  out  1  one-cycle pulse on divide by zero; md_timeout  out  1  sticky watchdog flag.

Function
REQ-013 SHALL decode only when id_instr[31:26]==0, using funct: 011000 mult, 011001 multu, 011010 div, 011011 divu, 010000 mfhi, 010001 mthi, 010010 mflo, 010011 mtlo; these eight are the HI/LO class.
REQ-014 SHALL implement FSM states IDLE, ISSUE, BUSY.
REQ-015 stall SHALL equal id_valid & HI/LO class & (state != IDLE); non-HI/LO instructions never stall.
REQ-016 In IDLE with id_valid and mult/multu, or div/divu with rt_val != 0: SHALL latch rs_val into md_a, rt_val into md_b, set md_op, and go to ISSUE.
REQ-017 In IDLE with id_valid and div/divu with rt_val == 0: SHALL pulse div0 for the following cycle, leave HI/LO unchanged, and stay IDLE.
REQ-018 In IDLE with id_valid and mthi or mtlo: SHALL write rs_val into HI or LO at that edge and stay IDLE.
REQ-019 mfhi/mflo SHALL have no state effect; the ID stage reads hi_out/lo_out directly.
REQ-020 md_start SHALL be 1 exactly during the ISSUE cycle; ISSUE SHALL go to BUSY on the next edge unless md_done is high.
REQ-021 md_done high in ISSUE or BUSY: SHALL write md_hi_res to HI and md_lo_res to LO at that edge and return to IDLE.
REQ-022 md_done in IDLE SHALL be ignored.
REQ-023 A 6-bit watchdog counter SHALL clear on ISSUE entry and increment each BUSY cycle.
REQ-024 When the counter reaches 48 in BUSY without md_done: SHALL set md_timeout, leave HI/LO unchanged, and return to IDLE.
REQ-025 Minimum HI/LO-to-mfhi latency SHALL be as follows: with op accepted at edge N and md_done in ISSUE, a dependent mfhi in ID is unstalled in cycle N+2.

Reset
REQ-026 rst_n low SHALL immediately, independent of clk, force: state IDLE, hi_out=lo_out=0, md_a=md_b=0, md_op=00, md_start=0, div0=0, md_timeout=0, counter=0.
REQ-027 Reset mid-operation SHALL abandon the op; a later md_done SHALL be ignored because state is IDLE.
REQ-028 md_timeout SHALL clear only on reset.

Verification
REQ-029 mult with rs=0x00000003, rt=0xFFFFFFFE; md_done in cycle 3 with hi=0xFFFFFFFF, lo=0xFFFFFFFA -> md_start pulses in cycle 1 with md_op=00; HI/LO updated after the edge ending cycle 3; a following mflo stalls cycles 1-3.
REQ-030 divu with rt=0 -> no md_start, div0=1 for one cycle, HI/LO unchanged, stall=0.
REQ-031 mthi with rs=0x12345678 in IDLE, then mfhi -> hi_out=0x12345678 in the next cycle, with no stall.
REQ-032 div issued and md_done never asserted -> after 48 BUSY cycles md_timeout=1, state IDLE, stall releases.
REQ-033 rst_n asserted low in BUSY, then md_done pulsed after release -> all outputs stay at reset values and HI/LO=0.
REQ-034 An add instruction in ID while BUSY -> stall=0; an mtlo in ID while BUSY -> stall=1 until md_done, then LO=rs_val one edge later.
